rsz_pxl_fwd: RTL
================

# rsz_pxl_fwd

Resized-pixel forwarder on the output side of the image resizer. It accepts one complete block-sum buffer per frame from the pooling accumulator and divides each block sum by the block pixel count (right shift). It then streams the resized pixels out one at a time, raster order, over a valid/ready interface. This block is the reader end of the full-colour block buffer the accumulator writes, and implements the serial forwarding mode (`RSZ_PXL_FWD_SER = 1`).

## Interface
Parameters:
- `PXL_PRIM_COLOR_NUM`, 1, primary colours per pixel
- `PXL_PRIM_COLOR_W`, 8, bits per primary colour
- `RSZ_IMG_WIDTH_SIZE`, 32, resized image width (pixels)
- `RSZ_IMG_HEIGHT_SIZE`, 16, resized image height (pixels)
- `BLK_MAX_SZ_W`, 11, log2 of the maximum block pixel count
- `BLK_SUM_MAX_W`, `PXL_PRIM_COLOR_W + BLK_MAX_SZ_W`, width of one block sum

Ports:
- `clk`, in, 1, single clock; all logic on the rising edge
- `rst_n`, in, 1, reset, asynchronous, active-low
- `blk_buf_vld`, in, 1, block buffer and shift are valid
- `blk_buf_rdy`, out, 1, forwarder can accept a buffer
- `blk_buf`, in, `PXL_PRIM_COLOR_NUM*RSZ_IMG_HEIGHT_SIZE*RSZ_IMG_WIDTH_SIZE*BLK_SUM_MAX_W`, packed as [colour][row][col][sum]
- `blk_shft`, in, `$clog2(BLK_MAX_SZ_W+1)`, log2 of block pixel count; 0 for max-pooling
- `rsz_pxl_vld`, out, 1, output pixel valid
- `rsz_pxl_rdy`, in, 1, downstream accepts the pixel
- `rsz_pxl_data`, out, `PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W`, full-colour resized pixel, packed as [colour][bits]
- `rsz_pxl_x`, out, `$clog2(RSZ_IMG_WIDTH_SIZE)`, column index of the current pixel
- `rsz_pxl_y`, out, `$clog2(RSZ_IMG_HEIGHT_SIZE)`, row index of the current pixel
- `rsz_pxl_last`, out, 1, current pixel is the final pixel of the frame

## Operation
- **FSM states:** IDLE, FWD.
- **IDLE:**
  - `blk_buf_rdy=1`, `rsz_pxl_vld=0`.
  - On `blk_buf_vld & blk_buf_rdy`, snapshot `blk_buf` and `blk_shft` into internal registers, clear x and y, go to FWD.
- **FWD:**
  - `blk_buf_rdy=0`, `rsz_pxl_vld=1`.
  - `rsz_pxl_data` is derived combinationally from the snapshot at (y,x).
  - On `rsz_pxl_vld & rsz_pxl_rdy`:
    - x increments.
    - At x=`RSZ_IMG_WIDTH_SIZE-1`, x wraps to 0 and y increments.
    - At the last pixel (x=W-1, y=H-1), go to IDLE and clear x and y.
- **Per-colour arithmetic:**
  - Effective shift s = min(`blk_shft`, `BLK_MAX_SZ_W`).
  - The quotient is computed at `BLK_SUM_MAX_W+1` bits, then saturated to `2^PXL_PRIM_COLOR_W-1` if it overflows.
  - Rounding mode follows `## Configuration`.
- `rsz_pxl_last` = FWD & x=W-1 & y=H-1.
- Input changes on `blk_buf` or `blk_shft` while in FWD are ignored; the snapshot is authoritative.
- `blk_buf_vld` held high while in FWD causes no action; it is accepted on return to IDLE.

## Timing
- **Reset values:**
  - `blk_buf_rdy=1`, `rsz_pxl_vld=0`, `rsz_pxl_data=0`, `rsz_pxl_x=0`, `rsz_pxl_y=0`, `rsz_pxl_last=0`.
  - FSM=IDLE, snapshot=0.
- **Latency:** buffer handshake in cycle T gives `rsz_pxl_vld=1` with pixel (0,0) in T+1.
- **Throughput:** one pixel per cycle while `rsz_pxl_rdy=1`. A frame takes W×H cycles plus one IDLE cycle between frames.
- **Stall behaviour:** while `rsz_pxl_vld & !rsz_pxl_rdy`, data, x, y and last hold stable. `rsz_pxl_vld` never drops until the handshake completes.
- **Last-pixel boundary:** the last-pixel handshake at cycle T gives IDLE in T+1 (`blk_buf_rdy=1`). The earliest next pixel is at T+2.
- **Mid-frame reset:** asserting `rst_n=0` mid-frame immediately (asynchronously) returns all outputs to reset values. The partially forwarded frame is discarded.

## Configuration
- Macro: `RSZ_FWD_ROUND_EN`.
- **Defined:** quotient = (sum + (s>0 ? 2^(s-1) : 0)) >> s, i.e. round-half-up, then saturate.
- **Undefined:** quotient = sum >> s, i.e. truncation, then saturate.
- Handshake and timing are identical in both modes.

## Test plan
- **Reset/idle:** assert `rst_n=0`, release, no stimulus → `blk_buf_rdy=1`, `rsz_pxl_vld=0`, all outputs 0 for 20 cycles.
- **Basic frame:**
  - Stimulus: 1 colour, every sum = 0x17F, `blk_shft=1`, `rsz_pxl_rdy=1`.
  - Response: 512 pixels starting the cycle after accept.
  - Data = 0xBF (truncate) or 0xC0 (`RSZ_FWD_ROUND_EN`).
  - Coordinates: x wraps 31→0 with y incrementing; `rsz_pxl_last` only on (31,15).
  - Pixel count: exactly 512 pixels.
- **Backpressure:**
  - Stimulus: sums = row*32+col, `blk_shft=0`, `rsz_pxl_rdy` toggled randomly.
  - Response: data, x and y stable during every stall. Sequence 0..255, with all sums ≥255 saturated to 0xFF.
- **Saturation/shift clamp:**
  - Stimulus: sum = 0x7FFFF, `blk_shft=0`, then `blk_shft=15`.
  - Response: 0xFF for `blk_shft=0`. For `blk_shft=15` (treated as 11), 0xFF both modes.
- **Back-to-back frames / snapshot:**
  - Stimulus: hold `blk_buf_vld=1` with a new buffer value driven during frame 1.
  - Response: frame 1 uses only the accepted snapshot. Frame 2 is accepted in the IDLE cycle after the last pixel, and its first pixel appears 2 cycles after the last handshake of frame 1.
- **Mid-frame reset:**
  - Stimulus: assert `rst_n=0` at pixel (5,3).
  - Response: outputs zero asynchronously. After release, `blk_buf_rdy=1` and the next frame starts at (0,0).

Source files
------------

// File: rtl/rsz_pxl_fwd_if.sv
// ---------------------------------------------------------------------------
// rsz_pxl_fwd_if
// Bundle of the block-buffer input handshake and the resized-pixel output
// stream of the resized-pixel forwarder.
//   master : the environment side (the accumulator that offers block buffers
//            and the downstream consumer that accepts pixels)
//   slave  : the forwarder itself
// Signals:
//   blk_buf_vld / blk_buf_rdy : block buffer handshake
//   blk_buf                   : block sums, packed [colour][row][col][sum]
//   blk_shft                  : log2 of block pixel count (0 = max-pooling)
//   rsz_pxl_vld / rsz_pxl_rdy : pixel stream handshake
//   rsz_pxl_data              : full-colour pixel, packed [colour][bits]
//   rsz_pxl_x / rsz_pxl_y     : raster coordinates of the current pixel
//   rsz_pxl_last              : final pixel of the frame
// ---------------------------------------------------------------------------
interface rsz_pxl_fwd_if #(
    parameter int PXL_PRIM_COLOR_NUM  = 1,
    parameter int PXL_PRIM_COLOR_W    = 8,
    parameter int RSZ_IMG_WIDTH_SIZE  = 32,
    parameter int RSZ_IMG_HEIGHT_SIZE = 16,
    parameter int BLK_MAX_SZ_W        = 11,
    parameter int BLK_SUM_MAX_W       = PXL_PRIM_COLOR_W + BLK_MAX_SZ_W
);
    localparam int BUF_W  = PXL_PRIM_COLOR_NUM * RSZ_IMG_HEIGHT_SIZE * RSZ_IMG_WIDTH_SIZE * BLK_SUM_MAX_W;
    localparam int SHFT_W = $clog2(BLK_MAX_SZ_W + 1);
    localparam int DATA_W = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;
    localparam int X_W    = $clog2(RSZ_IMG_WIDTH_SIZE);
    localparam int Y_W    = $clog2(RSZ_IMG_HEIGHT_SIZE);

    logic              blk_buf_vld;
    logic              blk_buf_rdy;
    logic [BUF_W-1:0]  blk_buf;
    logic [SHFT_W-1:0] blk_shft;
    logic              rsz_pxl_vld;
    logic              rsz_pxl_rdy;
    logic [DATA_W-1:0] rsz_pxl_data;
    logic [X_W-1:0]    rsz_pxl_x;
    logic [Y_W-1:0]    rsz_pxl_y;
    logic              rsz_pxl_last;

    modport master (
        output blk_buf_vld, blk_buf, blk_shft, rsz_pxl_rdy,
        input  blk_buf_rdy, rsz_pxl_vld, rsz_pxl_data, rsz_pxl_x, rsz_pxl_y, rsz_pxl_last
    );

    modport slave (
        input  blk_buf_vld, blk_buf, blk_shft, rsz_pxl_rdy,
        output blk_buf_rdy, rsz_pxl_vld, rsz_pxl_data, rsz_pxl_x, rsz_pxl_y, rsz_pxl_last
    );
endinterface

// File: rtl/rsz_pxl_fwd.sv
// ---------------------------------------------------------------------------
// rsz_pxl_fwd
// Resized-pixel forwarder. Accepts one block-sum buffer per frame, snapshots
// it together with the block shift, and streams the resized pixels out in
// raster order, one per cycle, dividing each sum by the block pixel count
// (right shift) and saturating to the pixel range.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rsz_pxl_fwd_if.slave (buffer handshake in, pixel stream out)
// Configuration macro:
//   RSZ_FWD_ROUND_EN : defined -> round-half-up before the shift,
//                      undefined -> truncating shift
// ---------------------------------------------------------------------------
module rsz_pxl_fwd #(
    parameter int PXL_PRIM_COLOR_NUM  = 1,
    parameter int PXL_PRIM_COLOR_W    = 8,
    parameter int RSZ_IMG_WIDTH_SIZE  = 32,
    parameter int RSZ_IMG_HEIGHT_SIZE = 16,
    parameter int BLK_MAX_SZ_W        = 11,
    parameter int BLK_SUM_MAX_W       = PXL_PRIM_COLOR_W + BLK_MAX_SZ_W
) (
    input logic           clk,
    input logic           rst_n,
    rsz_pxl_fwd_if.slave  bus
);
    localparam int SHFT_W = $clog2(BLK_MAX_SZ_W + 1);
    localparam int DATA_W = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;
    localparam int X_W    = $clog2(RSZ_IMG_WIDTH_SIZE);
    localparam int Y_W    = $clog2(RSZ_IMG_HEIGHT_SIZE);
    localparam int PW     = PXL_PRIM_COLOR_W;
    localparam int SUM_W  = BLK_SUM_MAX_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FWD  = 1'b1;

    localparam logic [X_W-1:0]    X_LAST   = X_W'(RSZ_IMG_WIDTH_SIZE - 1);
    localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(RSZ_IMG_HEIGHT_SIZE - 1);
    localparam logic [SHFT_W-1:0] SHFT_MAX = SHFT_W'(BLK_MAX_SZ_W);
    localparam logic [SUM_W:0]    PX_MAX   = {{(SUM_W + 1 - PW){1'b0}}, {PW{1'b1}}};

    // Divide one block sum by 2^s at one extra bit of headroom so the
    // rounding addend can never wrap, then clamp to the pixel range.
    function automatic logic [PW-1:0] div_sat(input logic [SUM_W-1:0] sum,
                                              input logic [SHFT_W-1:0] s);
        logic [SUM_W:0] ext;
        logic [SUM_W:0] quo;
        ext = {1'b0, sum};
`ifdef RSZ_FWD_ROUND_EN
        if (s != {SHFT_W{1'b0}}) begin
            ext = ext + ({{SUM_W{1'b0}}, 1'b1} << (s - SHFT_W'(1)));
        end else begin
            ext = ext;
        end
`else
        ext = ext;
`endif
        quo = ext >> s;
        if (quo > PX_MAX) begin
            div_sat = {PW{1'b1}};
        end else begin
            div_sat = quo[PW-1:0];
        end
    endfunction

    logic [0:0]  state_r;
    logic [X_W-1:0] x_r;
    logic [Y_W-1:0] y_r;
    logic [SHFT_W-1:0] shft_r;
    logic [PXL_PRIM_COLOR_NUM-1:0][RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0][SUM_W-1:0] snap_r;
    logic [SHFT_W-1:0] shft_eff_s;
    logic [DATA_W-1:0] data_s;

    // Clamp the requested shift to the largest meaningful block size.
    always_comb begin
        shft_eff_s = bus.blk_shft;
        if (bus.blk_shft > SHFT_MAX) begin
            shft_eff_s = SHFT_MAX;
        end else begin
            shft_eff_s = bus.blk_shft;
        end
    end

    // Frame state, raster position and buffer snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            x_r     <= '0;
            y_r     <= '0;
            shft_r  <= '0;
            snap_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.blk_buf_vld) begin
                        snap_r  <= bus.blk_buf;
                        shft_r  <= shft_eff_s;
                        x_r     <= '0;
                        y_r     <= '0;
                        state_r <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (bus.rsz_pxl_rdy) begin
                        if (x_r == X_LAST) begin
                            x_r <= '0;
                            if (y_r == Y_LAST) begin
                                y_r     <= '0;
                                state_r <= ST_IDLE;
                            end else begin
                                y_r <= y_r + Y_W'(1);
                            end
                        end else begin
                            x_r <= x_r + X_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    x_r     <= '0;
                    y_r     <= '0;
                end
            endcase
        end
    end

    // Pixel data straight from the snapshot; forced to zero outside a frame
    // so an idle forwarder presents a quiet bus.
    always_comb begin
        data_s = '0;
        if (state_r == ST_FWD) begin
            for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
                data_s[c*PW +: PW] = div_sat(snap_r[c][y_r][x_r], shft_r);
            end
        end else begin
            data_s = '0;
        end
    end

    assign bus.blk_buf_rdy  = (state_r == ST_IDLE);
    assign bus.rsz_pxl_vld  = (state_r == ST_FWD);
    assign bus.rsz_pxl_data = data_s;
    assign bus.rsz_pxl_x    = x_r;
    assign bus.rsz_pxl_y    = y_r;
    assign bus.rsz_pxl_last = (state_r == ST_FWD) && (x_r == X_LAST) && (y_r == Y_LAST);

endmodule
